add_approx_pipe: RTL and testbench

//  Parametrised, pipelined lower-part-OR approximate adder with valid/ready handshake.

---
 rtl/add_approx_pipe.sv | 165 ++++++++++++++++
 tb/tb_add_approx_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_approx_pipe.sv
// add_approx_pipe: two-stage lower-part-OR approximate adder with valid/ready flow control.
// Define ADD_APPROX_ERRMON_EN to add the inexact-result counter and max-error monitor.
module add_approx_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
`ifdef ADD_APPROX_ERRMON_EN
  ,
  input  logic             mon_clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]   err_max
`endif
);

  localparam int HI_W = WIDTH - APPROX_BITS;
  localparam int LO_W = (APPROX_BITS == 0) ? 1 : APPROX_BITS;

  if (APPROX_BITS < 0 || APPROX_BITS >= WIDTH || CNT_W < 1) begin : g_param_chk
    $error("add_approx_pipe: illegal WIDTH/APPROX_BITS/CNT_W combination");
  end

  logic            s2_adv;
  logic            s1_adv;
  logic            s1_valid_q, s1_valid_d;
  logic [HI_W-1:0] s1_a_q, s1_a_d;
  logic [HI_W-1:0] s1_b_q, s1_b_d;
  logic [LO_W-1:0] s1_lo_q, s1_lo_d;
  logic            s1_cin_q, s1_cin_d;
  logic [LO_W-1:0] lo_in;
  logic            cin_in;
  logic [HI_W:0]   hi_sum;
  logic [WIDTH:0]  approx_sum;
  logic            out_valid_q, out_valid_d;
  logic [WIDTH:0]  out_sum_q, out_sum_d;

  // With no approximated bits the low part vanishes and the upper add is the exact sum.
  if (APPROX_BITS == 0) begin : g_exact
    assign lo_in      = '0;
    assign cin_in     = 1'b0;
    assign approx_sum = hi_sum;
  end else begin : g_approx
    assign lo_in      = in_a[LO_W-1:0] | in_b[LO_W-1:0];
    assign cin_in     = in_a[LO_W-1] & in_b[LO_W-1];
    assign approx_sum = {hi_sum, s1_lo_q};
  end

  assign hi_sum = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{HI_W{1'b0}}, s1_cin_q};

  assign s2_adv    = !out_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_lo_d     = s1_lo_q;
    s1_cin_d    = s1_cin_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d   = in_a[WIDTH-1:APPROX_BITS];
        s1_b_d   = in_b[WIDTH-1:APPROX_BITS];
        s1_lo_d  = lo_in;
        s1_cin_d = cin_in;
      end
    end
    // out_sum only moves when stage 2 advances, so a stalled result stays put.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sum_d = approx_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_lo_q     <= '0;
      s1_cin_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_lo_q     <= s1_lo_d;
      s1_cin_q    <= s1_cin_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
    end
  end

`ifdef ADD_APPROX_ERRMON_EN
  logic [WIDTH:0]   s1_exact_q, s1_exact_d;
  logic [WIDTH:0]   s2_exact_q, s2_exact_d;
  logic [WIDTH:0]   err_e;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH:0]   err_max_q, err_max_d;

  // Exact sum rides alongside the approximate one, loaded under the same enables.
  always_comb begin
    s1_exact_d = s1_exact_q;
    s2_exact_d = s2_exact_q;
    if (s1_adv && in_valid) begin
      s1_exact_d = {1'b0, in_a} + {1'b0, in_b};
    end
    if (s2_adv && s1_valid_q) begin
      s2_exact_d = s1_exact_q;
    end
  end

  always_comb begin
    err_e     = (s2_exact_q >= out_sum_q) ? (s2_exact_q - out_sum_q) : (out_sum_q - s2_exact_q);
    err_cnt_d = err_cnt_q;
    err_max_d = err_max_q;
    if (mon_clr) begin
      err_cnt_d = '0;
      err_max_d = '0;
    end else if (out_valid_q && out_ready && (err_e != '0)) begin
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      if (err_e > err_max_q) begin
        err_max_d = err_e;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_exact_q <= '0;
      s2_exact_q <= '0;
      err_cnt_q  <= '0;
      err_max_q  <= '0;
    end else begin
      s1_exact_q <= s1_exact_d;
      s2_exact_q <= s2_exact_d;
      err_cnt_q  <= err_cnt_d;
      err_max_q  <= err_max_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign err_max = err_max_q;
`endif

endmodule

// File: tb/tb_add_approx_pipe.sv
// tb_add_approx_pipe: random and directed checks of add_approx_pipe (K=2 and exact K=0 instances)
// against an arithmetic reference model and in-order scoreboards.
module tb_add_approx_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_a, a_in_b;
  logic [8:0] a_out_sum;
  logic       x_in_valid, x_in_ready, x_out_valid, x_out_ready;
  logic [7:0] x_in_a, x_in_b;
  logic [8:0] x_out_sum;
`ifdef ADD_APPROX_ERRMON_EN
  logic        a_mon_clr, x_mon_clr;
  logic [15:0] a_err_cnt, x_err_cnt;
  logic [8:0]  a_err_max, x_err_max;
`endif

  add_approx_pipe #(.WIDTH(8), .APPROX_BITS(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_a(a_in_a), .in_b(a_in_b),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum)
`ifdef ADD_APPROX_ERRMON_EN
    , .mon_clr(a_mon_clr), .err_cnt(a_err_cnt), .err_max(a_err_max)
`endif
  );

  add_approx_pipe #(.WIDTH(8), .APPROX_BITS(0), .CNT_W(16)) u_exact (
    .clk(clk), .rst(rst),
    .in_valid(x_in_valid), .in_ready(x_in_ready), .in_a(x_in_a), .in_b(x_in_b),
    .out_valid(x_out_valid), .out_ready(x_out_ready), .out_sum(x_out_sum)
`ifdef ADD_APPROX_ERRMON_EN
    , .mon_clr(x_mon_clr), .err_cnt(x_err_cnt), .err_max(x_err_max)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: OR the low k bits, carry in from the AND of bit k-1, add the rest.
  function automatic logic [8:0] approx_ref(input logic [7:0] a, input logic [7:0] b, input int k);
    int ia, ib, lo, cin, hi;
    ia  = int'(a);
    ib  = int'(b);
    lo  = (ia | ib) % (1 << k);
    cin = (k > 0) ? (((ia >> (k - 1)) % 2) * ((ib >> (k - 1)) % 2)) : 0;
    hi  = (ia >> k) + (ib >> k) + cin;
    return 9'(hi * (1 << k) + lo);
  endfunction

  typedef struct {
    logic [8:0] approx;
    logic [8:0] exact;
  } beat_t;

  beat_t      aq[$];
  logic [8:0] xq[$];
  beat_t      ab;
  logic [8:0] xb;
  int         a_pops = 0;
  logic       a_hold = 1'b0, x_hold = 1'b0;
  logic [8:0] a_held, x_held;
  int         m_cnt = 0, m_max = 0, e_i;

  always @(negedge clk) begin
    if (rst) begin
      aq.delete();
      a_hold = 1'b0;
      m_cnt  = 0;
      m_max  = 0;
    end else begin
      if (a_hold && a_out_valid) chk("a_hold_stable", 32'(a_out_sum), 32'(a_held));
`ifdef ADD_APPROX_ERRMON_EN
      chk("err_cnt", 32'(a_err_cnt), 32'(m_cnt));
      chk("err_max", 32'(a_err_max), 32'(m_max));
`endif
      if (a_out_valid && a_out_ready) begin
        if (aq.size() == 0) begin
          chk("a_spurious_out", 32'(a_out_valid), 32'(0));
        end else begin
          ab = aq.pop_front();
          a_pops++;
          chk("a_sum", 32'(a_out_sum), 32'(ab.approx));
          e_i = int'(ab.exact) - int'(ab.approx);
          if (e_i < 0) e_i = -e_i;
`ifdef ADD_APPROX_ERRMON_EN
          if (!a_mon_clr && e_i != 0) begin
            if (m_cnt < 65535) m_cnt++;
            if (e_i > m_max) m_max = e_i;
          end
`endif
        end
      end
`ifdef ADD_APPROX_ERRMON_EN
      if (a_mon_clr) begin
        m_cnt = 0;
        m_max = 0;
      end
`endif
      a_hold = a_out_valid && !a_out_ready;
      a_held = a_out_sum;
      if (a_in_valid && a_in_ready)
        aq.push_back('{approx: approx_ref(a_in_a, a_in_b, 2), exact: 9'(a_in_a) + 9'(a_in_b)});
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      xq.delete();
      x_hold = 1'b0;
    end else begin
      if (x_hold && x_out_valid) chk("x_hold_stable", 32'(x_out_sum), 32'(x_held));
      if (x_out_valid && x_out_ready) begin
        if (xq.size() == 0) begin
          chk("x_spurious_out", 32'(x_out_valid), 32'(0));
        end else begin
          xb = xq.pop_front();
          chk("x_exact_sum", 32'(x_out_sum), 32'(xb));
        end
      end
      x_hold = x_out_valid && !x_out_ready;
      x_held = x_out_sum;
      if (x_in_valid && x_in_ready) xq.push_back(9'(int'(x_in_a) + int'(x_in_b)));
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic a_push(input logic [7:0] pa, input logic [7:0] pb);
    int n;
    n = 0;
    a_in_valid = 1'b1;
    a_in_a     = pa;
    a_in_b     = pb;
    @(negedge clk);
    while (!a_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("a_push_accept", 32'(a_in_ready), 32'(1));
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic a_directed(input logic [7:0] pa, input logic [7:0] pb, input logic [8:0] exp);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_a      = pa;
    a_in_b      = pb;
    @(negedge clk);
    chk("dir_in_ready", 32'(a_in_ready), 32'(1));
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("dir_lat1_valid", 32'(a_out_valid), 32'(0));
    @(negedge clk);
    chk("dir_lat2_valid", 32'(a_out_valid), 32'(1));
    chk("dir_lat2_sum", 32'(a_out_sum), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    a_out_ready = 1'b1;
    x_out_ready = 1'b1;
    @(negedge clk);
    while ((aq.size() != 0 || xq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_a", 32'(aq.size()), 32'(0));
    chk("drain_x", 32'(xq.size()), 32'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   p0, n, a_sent, x_sent;
  logic a_acc, x_acc;

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_a = '0; a_in_b = '0; a_out_ready = 1'b0;
    x_in_valid = 1'b0; x_in_a = '0; x_in_b = '0; x_out_ready = 1'b0;
`ifdef ADD_APPROX_ERRMON_EN
    a_mon_clr = 1'b0;
    x_mon_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(a_out_valid), 32'(0));
    chk("rst_out_sum", 32'(a_out_sum), 32'(0));
    chk("rst_in_ready", 32'(a_in_ready), 32'(1));
    chk("rst_x_in_ready", 32'(x_in_ready), 32'(1));

    @(posedge clk); #1;
    a_directed(8'h0F, 8'h01, 9'h00F);
    a_directed(8'hFF, 8'hFF, 9'h1FF);
    a_directed(8'h03, 8'h03, 9'h007);

    // Backpressure: two beats fill the pipe, the third waits, then full pop+push.
    a_out_ready = 1'b0;
    p0 = a_pops;
    a_push(8'h11, 8'h22);
    a_push(8'h33, 8'h44);
    a_in_valid = 1'b1;
    a_in_a     = 8'h55;
    a_in_b     = 8'h66;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(a_in_ready), 32'(0));
      chk("stall_out_valid", 32'(a_out_valid), 32'(1));
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("full_push_pop_ready", 32'(a_in_ready), 32'(1));
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("full_stays_valid", 32'(a_out_valid), 32'(1));
    @(posedge clk); #1;
    drain();
    chk("stall_beats_out", 32'(a_pops - p0), 32'(3));

    // Reset with beats in flight discards them.
    a_out_ready = 1'b0;
    a_push(8'h01, 8'h02);
    a_push(8'h03, 8'h04);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(a_out_valid), 32'(0));
    chk("midrst_out_sum", 32'(a_out_sum), 32'(0));
    chk("midrst_in_ready", 32'(a_in_ready), 32'(1));
    repeat (3) @(negedge clk);
    chk("midrst_no_out", 32'(a_out_valid), 32'(0));
    @(posedge clk); #1;

    // Random traffic with random backpressure on both instances.
    a_sent = 0; x_sent = 0; a_acc = 1'b0; x_acc = 1'b0; n = 0;
    while ((a_sent < 300 || x_sent < 1000) && n < 20000) begin
      if (a_acc || !a_in_valid) begin
        a_in_valid = (a_sent < 300) && ($urandom_range(3) != 0);
        a_in_a     = 8'($urandom);
        a_in_b     = 8'($urandom);
      end
      if (x_acc || !x_in_valid) begin
        x_in_valid = (x_sent < 1000) && ($urandom_range(3) != 0);
        x_in_a     = 8'($urandom);
        x_in_b     = 8'($urandom);
      end
      a_out_ready = 1'($urandom);
      x_out_ready = 1'($urandom);
`ifdef ADD_APPROX_ERRMON_EN
      a_mon_clr = ($urandom_range(15) == 0);
`endif
      @(negedge clk);
      a_acc = a_in_valid && a_in_ready;
      x_acc = x_in_valid && x_in_ready;
      if (a_acc) a_sent++;
      if (x_acc) x_sent++;
      @(posedge clk); #1;
      n++;
    end
    a_in_valid = 1'b0;
    x_in_valid = 1'b0;
`ifdef ADD_APPROX_ERRMON_EN
    a_mon_clr = 1'b0;
`endif
    chk("rand_a_sent", 32'(a_sent), 32'(300));
    chk("rand_x_sent", 32'(x_sent), 32'(1000));
    drain();

`ifdef ADD_APPROX_ERRMON_EN
    a_mon_clr = 1'b1;
    @(posedge clk); #1;
    a_mon_clr = 1'b0;
    a_push(8'h0F, 8'h01);
    a_push(8'h02, 8'h02);
    a_push(8'h10, 8'h10);
    drain();
    @(negedge clk);
    chk("mon_err_cnt", 32'(a_err_cnt), 32'(2));
    chk("mon_err_max", 32'(a_err_max), 32'(2));
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    a_push(8'h02, 8'h02);
    n = 0;
    while (!a_out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mon_clr_out_valid", 32'(a_out_valid), 32'(1));
    a_out_ready = 1'b1;
    a_mon_clr   = 1'b1;
    @(posedge clk); #1;
    a_mon_clr = 1'b0;
    @(negedge clk);
    chk("mon_clr_cnt", 32'(a_err_cnt), 32'(0));
    chk("mon_clr_max", 32'(a_err_max), 32'(0));
    @(posedge clk); #1;
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
